seg7_scan_driver: RTL and testbench

Four-digit seven-segment display scanner driven by the divided slow clock. It samples slow_clock in the CLOCK domain and converts its rising edges to one-cycle ticks. It prescales those ticks to a digit-scan rate and time-multiplexes a 4-digit hex value onto the board's shared active-low segment/anode pins. Display data is latched once per frame so digits never tear mid-scan.

---
 rtl/seg7_scan_driver.sv | 120 ++++++++++++
 tb/tb_seg7_scan_driver.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver: slow_clock rising edges are
// prescaled into digit slots, and display data is latched once per frame.
module seg7_scan_driver #(
   parameter int TICKS_PER_DIGIT = 4096,
   parameter int CNT_W           = 16
) (
   input  logic        CLOCK,
   input  logic        RESET,
   input  logic        slow_clock,
   input  logic [15:0] digits,
   input  logic [3:0]  dp_in,
   input  logic [3:0]  blank_in,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [3:0]  an,
   output logic        frame_tick
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_DIGIT - 1);

   logic             slow_q;
   logic             tick;
   logic             adv;
   logic             wrap;
   logic             load;
   logic [CNT_W-1:0] count_reg, count_next;
   logic [1:0]       idx_reg, idx_next;
   logic             load_pending;
   logic [15:0]      sh_digits;
   logic [3:0]       sh_dp;
   logic [3:0]       sh_blank;
   logic [6:0]       seg_dec [4];
   logic [3:0]       an_next;
   logic [6:0]       seg_next;
   logic             dp_next;

   // Active-low gfedcba patterns.
   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: hex7 = 7'b1000000;
         4'h1: hex7 = 7'b1111001;
         4'h2: hex7 = 7'b0100100;
         4'h3: hex7 = 7'b0110000;
         4'h4: hex7 = 7'b0011001;
         4'h5: hex7 = 7'b0010010;
         4'h6: hex7 = 7'b0000010;
         4'h7: hex7 = 7'b1111000;
         4'h8: hex7 = 7'b0000000;
         4'h9: hex7 = 7'b0010000;
         4'hA: hex7 = 7'b0001000;
         4'hB: hex7 = 7'b0000011;
         4'hC: hex7 = 7'b1000110;
         4'hD: hex7 = 7'b0100001;
         4'hE: hex7 = 7'b0000110;
         default: hex7 = 7'b0001110;
      endcase
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_dec
         assign seg_dec[gi] = hex7(sh_digits[gi*4 +: 4]);
      end
   endgenerate

   always_comb begin
      tick       = slow_clock & ~slow_q;
      adv        = tick && (count_reg == LAST);
      count_next = count_reg;
      if (tick) begin
         count_next = adv ? '0 : count_reg + CNT_W'(1);
      end
      idx_next = adv ? idx_reg + 2'd1 : idx_reg;
      wrap     = adv && (idx_reg == 2'd3);
      // The pending flag makes the first post-reset cycle capture the inputs.
      load     = wrap || load_pending;
   end

   always_comb begin
      an_next  = 4'b1111;
      seg_next = 7'b1111111;
      dp_next  = 1'b1;
      if (!sh_blank[idx_reg]) begin
         an_next  = ~(4'b0001 << idx_reg);
         seg_next = seg_dec[idx_reg];
         dp_next  = ~sh_dp[idx_reg];
      end
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         slow_q       <= 1'b0;
         count_reg    <= '0;
         idx_reg      <= 2'd0;
         load_pending <= 1'b1;
         sh_digits    <= 16'h0000;
         sh_dp        <= 4'b0000;
         sh_blank     <= 4'b1111;
         an           <= 4'b1111;
         seg          <= 7'b1111111;
         dp           <= 1'b1;
         frame_tick   <= 1'b0;
      end else begin
         slow_q     <= slow_clock;
         count_reg  <= count_next;
         idx_reg    <= idx_next;
         frame_tick <= wrap;
         if (load) begin
            sh_digits    <= digits;
            sh_dp        <= dp_in;
            sh_blank     <= blank_in;
            load_pending <= 1'b0;
         end
         an  <= an_next;
         seg <= seg_next;
         dp  <= dp_next;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a tick-count reference model predicts every
// output cycle, plus scenario checks against the fixed decode table.
module tb_seg7_scan_driver;

   localparam int TPD   = 2;
   localparam int FRAME = 4 * TPD * 6;

   localparam logic [6:0] HEX [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   logic        CLOCK = 1'b0;
   logic        RESET = 1'b1;
   logic        slow_clock = 1'b0;
   logic [15:0] digits = 16'h1A2F;
   logic [3:0]  dp_in = 4'b0000;
   logic [3:0]  blank_in = 4'b0000;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        frame_tick;

   int passed = 0;
   int total  = 0;

   bit slow_run = 1'b0;
   int slow_div = 0;

   seg7_scan_driver #(.TICKS_PER_DIGIT(TPD), .CNT_W(16)) dut (
      .CLOCK(CLOCK), .RESET(RESET), .slow_clock(slow_clock),
      .digits(digits), .dp_in(dp_in), .blank_in(blank_in),
      .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick));

   always #5 CLOCK = ~CLOCK;

   // slow_clock toggles every 3 CLOCKs while enabled, otherwise held low.
   always @(negedge CLOCK) begin
      if (!slow_run) begin
         slow_clock = 1'b0;
         slow_div   = 0;
      end else if (slow_div == 2) begin
         slow_div   = 0;
         slow_clock = ~slow_clock;
      end else begin
         slow_div++;
      end
   end

   // Reference model: the slot is the number of rising edges seen since reset
   // divided by TPD; a frame starts whenever that count reaches a multiple of 4*TPD.
   int          m_ticks;
   logic        m_prev;
   bit          m_pending;
   logic [15:0] m_dig;
   logic [3:0]  m_dp, m_bl;
   logic [3:0]  exp_an  = 4'b1111;
   logic [6:0]  exp_seg = 7'b1111111;
   logic        exp_dp  = 1'b1;
   logic        exp_ft  = 1'b0;

   always @(posedge CLOCK) begin
      int slot;
      bit tk;
      if (RESET) begin
         m_ticks = 0; m_prev = 1'b0; m_pending = 1'b1;
         m_dig = 16'h0; m_dp = 4'h0; m_bl = 4'hF;
         exp_an = 4'b1111; exp_seg = 7'b1111111; exp_dp = 1'b1; exp_ft = 1'b0;
      end else begin
         slot = (m_ticks / TPD) % 4;
         if (m_bl[slot]) begin
            exp_an = 4'b1111; exp_seg = 7'b1111111; exp_dp = 1'b1;
         end else begin
            exp_an  = ~(4'b0001 << slot);
            exp_seg = HEX[4'(m_dig >> (4 * slot))];
            exp_dp  = ~m_dp[slot];
         end
         tk     = slow_clock && !m_prev;
         m_prev = slow_clock;
         exp_ft = 1'b0;
         if (tk) begin
            m_ticks++;
            if (m_ticks % (4 * TPD) == 0) exp_ft = 1'b1;
         end
         if (m_pending || (tk && (m_ticks % (4 * TPD) == 0))) begin
            m_dig = digits; m_dp = dp_in; m_bl = blank_in;
            m_pending = 1'b0;
         end
      end
   end

   task automatic test_reset();
      RESET = 1'b1;
      repeat (3) @(negedge CLOCK);
      total++;
      if ({an, seg, dp, frame_tick} !== {4'b1111, 7'b1111111, 1'b1, 1'b0})
         $display("FAIL reset_state: an=%b seg=%b dp=%b ft=%b want 1111 1111111 1 0", an, seg, dp, frame_tick);
      else passed++;
      RESET    = 1'b0;
      slow_run = 1'b1;
      @(negedge CLOCK);
      total++;
      if (an !== 4'b1111)
         $display("FAIL first_cycle_dark: an=%b want 1111", an);
      else passed++;
      @(negedge CLOCK);
      total++;
      if ({an, seg} !== {4'b1110, 7'b0001110})
         $display("FAIL after_release: an=%b seg=%b want 1110 0001110", an, seg);
      else passed++;
   endtask

   task automatic test_scan_order();
      logic [10:0] order [4] = '{{4'b1110, 7'b0001110}, {4'b1101, 7'b0100100},
                                 {4'b1011, 7'b0001000}, {4'b0111, 7'b1111001}};
      logic [3:0] prev_an = an;
      int k = 0, last = 0;
      bit seen = 1'b0;
      for (int c = 1; c <= 2 * FRAME; c++) begin
         @(negedge CLOCK);
         total++;
         if ({an, seg, dp, frame_tick} !== {exp_an, exp_seg, exp_dp, exp_ft})
            $display("FAIL scan_model: an=%b seg=%b dp=%b ft=%b want %b %b %b %b", an, seg, dp, frame_tick, exp_an, exp_seg, exp_dp, exp_ft);
         else passed++;
         if (an !== prev_an) begin
            k = (k + 1) % 4;
            total++;
            if ({an, seg} !== order[k])
               $display("FAIL scan_step: an=%b seg=%b want %b", an, seg, order[k]);
            else passed++;
            if (seen) begin
               total++;
               if (c - last != 12)
                  $display("FAIL slot_period: got %0d cycles want 12", c - last);
               else passed++;
            end
            seen = 1'b1; last = c; prev_an = an;
         end
      end
   endtask

   task automatic test_frame_tick();
      int pulses = 0, last = -1;
      for (int c = 0; c < 5 * FRAME; c++) begin
         @(negedge CLOCK);
         total++;
         if (frame_tick !== exp_ft)
            $display("FAIL frame_tick_model: got %b want %b", frame_tick, exp_ft);
         else passed++;
         if (frame_tick === 1'b1) begin
            pulses++;
            total++;
            if (an !== 4'b0111)
               $display("FAIL frame_tick_align: an=%b want 0111", an);
            else passed++;
            if (last >= 0) begin
               total++;
               if (c - last != FRAME)
                  $display("FAIL frame_tick_spacing: got %0d want %0d", c - last, FRAME);
               else passed++;
            end
            last = c;
         end
      end
      total++;
      if (pulses != 5)
         $display("FAIL frame_tick_count: got %0d want 5", pulses);
      else passed++;
   endtask

   task automatic test_latch();
      bit found = 1'b0;
      bit wrapped = 1'b0;
      logic [6:0] old_seg [4] = '{7'b0001110, 7'b0100100, 7'b0001000, 7'b1111001};
      for (int c = 0; c < 100 && !found; c++) begin
         @(negedge CLOCK);
         if (an === 4'b1101) found = 1'b1;
      end
      total++;
      if (!found) $display("FAIL latch_wait_slot1: an=%b want 1101 within 100 cycles", an);
      else passed++;
      digits = 16'h0000;
      for (int c = 0; c < 2 * FRAME; c++) begin
         @(negedge CLOCK);
         total++;
         if ({an, seg, dp, frame_tick} !== {exp_an, exp_seg, exp_dp, exp_ft})
            $display("FAIL latch_model: an=%b seg=%b want %b %b", an, seg, exp_an, exp_seg);
         else passed++;
         if (an === 4'b1110) wrapped = 1'b1;
         for (int s = 0; s < 4; s++) begin
            if (an === ~(4'b0001 << s)) begin
               total++;
               if (seg !== (wrapped ? 7'b1000000 : old_seg[s]))
                  $display("FAIL latch_seg: slot %0d seg=%b want %b", s, seg, wrapped ? 7'b1000000 : old_seg[s]);
               else passed++;
            end
         end
      end
   endtask

   task automatic test_blank_dp();
      int dark = 0;
      blank_in = 4'b0101;
      dp_in    = 4'b1000;
      for (int c = 0; c < 3 * FRAME; c++) begin
         @(negedge CLOCK);
         total++;
         if ({an, seg, dp, frame_tick} !== {exp_an, exp_seg, exp_dp, exp_ft})
            $display("FAIL blank_model: an=%b seg=%b dp=%b want %b %b %b", an, seg, dp, exp_an, exp_seg, exp_dp);
         else passed++;
         total++;
         if ($countones(~an) > 1)
            $display("FAIL one_anode: an=%b want at most one low", an);
         else passed++;
         if (c >= 2 * FRAME) begin
            if (an === 4'b1111) begin
               dark++;
               total++;
               if ({seg, dp} !== {7'b1111111, 1'b1})
                  $display("FAIL blank_seg: seg=%b dp=%b want 1111111 1", seg, dp);
               else passed++;
            end
            total++;
            if ((dp === 1'b0) !== (an === 4'b0111))
               $display("FAIL dp_slot3: dp=%b an=%b want dp=0 only with an=0111", dp, an);
            else passed++;
         end
      end
      total++;
      if (dark != FRAME / 2)
         $display("FAIL blank_slots: dark cycles %0d want %0d", dark, FRAME / 2);
      else passed++;
   endtask

   task automatic test_reset_mid();
      bit found = 1'b0;
      blank_in = 4'b0000; dp_in = 4'b0000; digits = 16'h1A2F;
      for (int c = 0; c < 2 * FRAME; c++) begin
         @(negedge CLOCK);
         if (an === 4'b1011) found = 1'b1;
         if (found && c >= FRAME) break;
      end
      found = 1'b0;
      for (int c = 0; c < FRAME && !found; c++) begin
         @(negedge CLOCK);
         if (an === 4'b1011) found = 1'b1;
      end
      total++;
      if (!found) $display("FAIL reset_mid_wait: an=%b want 1011 within a frame", an);
      else passed++;
      @(negedge CLOCK);
      RESET = 1'b1;
      @(negedge CLOCK);
      RESET = 1'b0;
      total++;
      if ({an, seg, dp} !== {4'b1111, 7'b1111111, 1'b1})
         $display("FAIL reset_mid_dark: an=%b seg=%b dp=%b want 1111 1111111 1", an, seg, dp);
      else passed++;
      found = 1'b0;
      for (int c = 0; c < 6 && !found; c++) begin
         @(negedge CLOCK);
         if (an === 4'b1110) found = 1'b1;
      end
      total++;
      if (!found || seg !== 7'b0001110)
         $display("FAIL reset_mid_resume: an=%b seg=%b want 1110 0001110", an, seg);
      else passed++;
      repeat (FRAME) begin
         @(negedge CLOCK);
         total++;
         if ({an, seg, dp, frame_tick} !== {exp_an, exp_seg, exp_dp, exp_ft})
            $display("FAIL reset_mid_model: an=%b seg=%b want %b %b", an, seg, exp_an, exp_seg);
         else passed++;
      end
   endtask

   task automatic test_hold_and_decode();
      logic [11:0] snap;
      bit bad = 1'b0;
      slow_run = 1'b0;
      repeat (3) @(negedge CLOCK);
      snap = {an, seg, dp};
      repeat (200) begin
         @(negedge CLOCK);
         if ({an, seg, dp} !== snap || frame_tick !== 1'b0) bad = 1'b1;
      end
      total++;
      if (bad) $display("FAIL hold_stuck_low: outputs moved, now %b want %b", {an, seg, dp}, snap);
      else passed++;
      for (int v = 0; v < 16; v++) begin
         digits = {4{4'(v)}};
         RESET  = 1'b1;
         @(negedge CLOCK);
         RESET  = 1'b0;
         repeat (2) @(negedge CLOCK);
         total++;
         if ({an, seg} !== {4'b1110, HEX[v]})
            $display("FAIL decode_%h: an=%b seg=%b want 1110 %b", v, an, seg, HEX[v]);
         else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_scan_order();
      test_frame_tick();
      test_latch();
      test_blank_dp();
      test_reset_mid();
      test_hold_and_decode();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
